// File: rtl/seven_seg_capture_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seven_seg_pkg
// Description : Shared 7-segment types, pattern constants and capture states.
//               Bit order of a pattern is {g,f,e,d,c,b,a}, active-high.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

  // Capture FSM: IDLE = nothing tracked since reset, COUNT = qualifying a
  // sample, LOCKED = current sample already processed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } cap_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_capture_if.sv
`default_nettype none
// ============================================================================
// Interface   : seven_seg_capture_if
// Description : Multiplexed 7-segment link plus recovered-digit outputs.
//               master = display-side driver / observer, slave = capture.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_capture_if;
  import seven_seg_pkg::*;

  seg_t    segment_in;
  logic    digit_sel_in;
  nibble_t hi_digit;
  nibble_t lo_digit;
  logic    hi_valid;
  logic    lo_valid;
  logic    frame_strobe;
  logic    pattern_err;

  modport master (
    output segment_in, digit_sel_in,
    input  hi_digit, lo_digit, hi_valid, lo_valid, frame_strobe, pattern_err
  );

  modport slave (
    input  segment_in, digit_sel_in,
    output hi_digit, lo_digit, hi_valid, lo_valid, frame_strobe, pattern_err
  );

endinterface : seven_seg_capture_if
`default_nettype wire

// File: rtl/seven_seg_capture_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decode
// Description : Combinational pattern classifier: legal hex glyph, blank, or
//               neither (illegal). value is 0 unless the pattern is legal.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  seg_t    seg_i,
  output logic    legal_o,
  output logic    blank_o,
  output nibble_t value_o
);

  // Map each glyph back to its hex value.
  always_comb begin
    legal_o = 1'b1;
    value_o = 4'h0;
    blank_o = (seg_i == SEG_BLANK);
    case (seg_i)
      SEG_0:   value_o = 4'h0;
      SEG_1:   value_o = 4'h1;
      SEG_2:   value_o = 4'h2;
      SEG_3:   value_o = 4'h3;
      SEG_4:   value_o = 4'h4;
      SEG_5:   value_o = 4'h5;
      SEG_6:   value_o = 4'h6;
      SEG_7:   value_o = 4'h7;
      SEG_8:   value_o = 4'h8;
      SEG_9:   value_o = 4'h9;
      SEG_A:   value_o = 4'hA;
      SEG_B:   value_o = 4'hB;
      SEG_C:   value_o = 4'hC;
      SEG_D:   value_o = 4'hD;
      SEG_E:   value_o = 4'hE;
      SEG_F:   value_o = 4'hF;
      default: legal_o = 1'b0;
    endcase
  end

endmodule : seven_seg_decode
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_capture
// Description : Receive side of a two-digit multiplexed 7-segment link.
//               A {digit_sel, segment} sample is accepted once it has been
//               seen STABLE consecutive cycles; frames are a high digit
//               followed directly by a low digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE = 4,
  parameter int CW     = 3
) (
  input  wire                  clk,
  input  wire                  rst,
  seven_seg_capture_if.slave   bus
);

  localparam logic [CW-1:0] C_LAST = CW'(STABLE - 1);

  cap_state_t    state_q, state_d;
  logic [7:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_seen_q, hi_seen_d;
  nibble_t       hi_digit_q, hi_digit_d;
  nibble_t       lo_digit_q, lo_digit_d;
  logic          hi_valid_q, hi_valid_d;
  logic          lo_valid_q, lo_valid_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;

  logic [7:0]    w_sample;
  logic          w_legal;
  logic          w_blank;
  nibble_t       w_value;

  assign w_sample = {bus.digit_sel_in, bus.segment_in};

  seven_seg_decode u_decode (
    .seg_i   (bus.segment_in),
    .legal_o (w_legal),
    .blank_o (w_blank),
    .value_o (w_value)
  );

  // Register all capture state; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= 8'h00;
      cnt_q      <= '0;
      hi_seen_q  <= 1'b0;
      hi_digit_q <= 4'h0;
      lo_digit_q <= 4'h0;
      hi_valid_q <= 1'b0;
      lo_valid_q <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      hi_seen_q  <= hi_seen_d;
      hi_digit_q <= hi_digit_d;
      lo_digit_q <= lo_digit_d;
      hi_valid_q <= hi_valid_d;
      lo_valid_q <= lo_valid_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  // Next state: restart qualification on any change, process on the
  // STABLE-th equal sample, then sit locked until the bus moves.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    hi_seen_d  = hi_seen_q;
    hi_digit_d = hi_digit_q;
    lo_digit_d = lo_digit_q;
    hi_valid_d = hi_valid_q;
    lo_valid_d = lo_valid_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;

    if (w_sample != prev_q) begin
      prev_d  = w_sample;
      cnt_d   = CW'(1);
      state_d = ST_COUNT;
    end else if (state_q == ST_COUNT) begin
      if (cnt_q == C_LAST) begin
        state_d = ST_LOCKED;
        if (w_legal) begin
          if (bus.digit_sel_in) begin
            hi_digit_d = w_value;
            hi_valid_d = 1'b1;
            hi_seen_d  = 1'b1;
          end else begin
            lo_digit_d = w_value;
            lo_valid_d = 1'b1;
            strobe_d   = hi_seen_q;
            hi_seen_d  = 1'b0;
          end
        end else if (!w_blank) begin
          err_d     = 1'b1;
          hi_seen_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign bus.hi_digit     = hi_digit_q;
  assign bus.lo_digit     = lo_digit_q;
  assign bus.hi_valid     = hi_valid_q;
  assign bus.lo_valid     = lo_valid_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.pattern_err  = err_q;

endmodule : seven_seg_capture
`default_nettype wire
